// File: rtl/sys_bus_arbiter_if.sv
// Bus-side signals of the system bus arbiter: requests in, grant/hold/timeout out.
interface sys_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic                   grant_valid;
  logic [1:0]             grant_id;
  logic [NUM_MASTERS-1:0] hold;
  logic                   hold_any;
  logic                   timeout;

  modport master (
    output req,
    input  grant, grant_valid, grant_id, hold, hold_any, timeout
  );

  modport slave (
    input  req,
    output grant, grant_valid, grant_id, hold, hold_any, timeout
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Registered round-robin bus arbiter with grant lock and per-master hold flags.
// Define SYS_BUS_ARB_TIMEOUT_EN to add the grant watchdog (hold_cnt + revoke mask).
module sys_bus_arbiter_lane (
  input  logic req,
  input  logic grant,
  output logic hold
);
  assign hold = req & ~grant;
endmodule

module sys_bus_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_HOLD_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  sys_bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWNED} state_e;
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || MAX_HOLD_CYCLES < 2 || MAX_HOLD_CYCLES > 255)
  begin : g_bad_param
    $error("sys_bus_arbiter: parameter out of range");
  end

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, mask_q, elig, hold;
  logic                   grant_valid_q, grant_valid_d, timeout_q, timeout_d;
  logic [1:0]             grant_id_q, grant_id_d, ptr_q, ptr_d, start, nxt, win;
  logic [3:0]             req_x;
  logic                   arb, found, revoke;

  assign req_x = 4'(bus.req);
  assign nxt   = (int'(grant_id_q) == NUM_MASTERS - 1) ? 2'd0 : grant_id_q + 2'd1;

`ifdef SYS_BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD_CYCLES - 1);
  logic [NUM_MASTERS-1:0] mask_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;

  assign revoke = (state_q == OWNED) && req_x[grant_id_q] && (hold_cnt_q == HOLD_LAST);
  // A revoked master stays masked until it lets go of req at least once.
  assign mask_d = (mask_q & bus.req) | (revoke ? grant_q : '0);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (arb)                   hold_cnt_d = 8'd0;
    else if (state_q == OWNED) hold_cnt_d = hold_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      hold_cnt_q <= 8'd0;
    end else begin
      mask_q     <= mask_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign revoke = 1'b0;
  assign mask_q = '0;
`endif

  // Arbitrate from IDLE, or at the edge the owner leaves (release or revoke).
  always_comb begin
    arb   = 1'b0;
    start = ptr_q;
    ptr_d = ptr_q;
    elig  = bus.req & ~mask_q;
    if (state_q == IDLE) begin
      arb = 1'b1;
    end else if (!req_x[grant_id_q] || revoke) begin
      arb   = 1'b1;
      start = nxt;
      ptr_d = nxt;
      elig  = elig & ~grant_q;
    end
  end

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      int idx;
      idx = int'(start) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = 2'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    timeout_d  = revoke;
    if (arb) begin
      if (found) begin
        state_d    = OWNED;
        grant_d    = ONE << win;
        grant_id_d = win;
      end else begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = 2'd0;
      end
    end
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 2'd0;
      ptr_q         <= 2'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      timeout_q     <= timeout_d;
    end
  end

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    sys_bus_arbiter_lane u_lane (.req(bus.req[i]), .grant(grant_q[i]), .hold(hold[i]));
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.hold        = hold;
  assign bus.hold_any    = |hold;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed scenarios plus random requests against a
// transaction-level round-robin model (owner index, pointer, mask set).
module tb_sys_bus_arbiter;
  localparam int N    = 4;
  localparam int MAXH = 4;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  sys_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();
  sys_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD_CYCLES(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  int     m_owner, m_ptr, m_cnt;
  bit [N-1:0] m_mask;
  bit     m_tmo;

  function automatic logic [N-1:0] m_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_mask = '0; m_tmo = 1'b0;
  endtask

  // One clock edge of the arbitration rules, applied to the request vector r.
  task automatic model_edge(input logic [N-1:0] r);
    bit arb, rev;
    int start;
    bit [N-1:0] elig;
    arb = 0; rev = 0; start = m_ptr; elig = r & ~m_mask; m_tmo = 1'b0;
    if (m_owner < 0) arb = 1;
    else if (!r[m_owner] || (TMO_EN && m_cnt == MAXH - 1)) begin
      rev = r[m_owner]; arb = 1;
      start = (m_owner + 1) % N; m_ptr = start; elig[m_owner] = 1'b0;
    end else m_cnt++;
    for (int i = 0; i < N; i++) if (!r[i]) m_mask[i] = 1'b0;
    if (rev) begin m_mask[m_owner] = 1'b1; m_tmo = 1'b1; end
    if (arb) begin
      m_owner = -1;
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && elig[(start + k) % N]) m_owner = (start + k) % N;
      m_cnt = 0;
    end
  endtask

  task automatic drive(input logic [N-1:0] r);
    @(negedge clk); bus.req = r;
    @(posedge clk); model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; model_reset(); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.grant, bus.grant_valid, bus.grant_id, bus.timeout} !== 8'h00) begin
      n_err++; $display("FAIL reset_init: got %b want 00000000",
                        {bus.grant, bus.grant_valid, bus.grant_id, bus.timeout});
    end
    drive(4'b0001); drive(4'b0001);
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_err++; $display("FAIL reset_pregrant: got %b want 0001", bus.grant);
    end
    @(negedge clk); bus.req = 4'b0101; #2 rst_n = 1'b0; #1;
    n_cmp++;
    if ({bus.grant, bus.grant_valid, bus.grant_id, bus.timeout} !== 8'h00) begin
      n_err++; $display("FAIL reset_async: got %b want 00000000",
                        {bus.grant, bus.grant_valid, bus.grant_id, bus.timeout});
    end
    n_cmp++;
    if (bus.hold !== 4'b0101) begin
      n_err++; $display("FAIL reset_hold: got %b want 0101", bus.hold);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0001);
    n_cmp++;
    if ({bus.grant, bus.grant_valid, bus.grant_id} !== 7'b0001_1_00) begin
      n_err++; $display("FAIL single_first: got %b want 0001100",
                        {bus.grant, bus.grant_valid, bus.grant_id});
    end
    for (int c = 2; c <= 4; c++) begin
      drive(4'b0001);
      n_cmp++;
      if (bus.grant !== 4'b0001) begin
        n_err++; $display("FAIL single_held c%0d: got %b want 0001", c, bus.grant);
      end
    end
    drive(4'b0000);
    n_cmp++;
    if ({bus.grant, bus.grant_valid, bus.grant_id} !== 7'b0) begin
      n_err++; $display("FAIL single_release: got %b want 0000000",
                        {bus.grant, bus.grant_valid, bus.grant_id});
    end
  endtask

  task automatic test_contention();
    do_reset();
    drive(4'b0011);
    n_cmp++;
    if ({bus.grant, bus.hold, bus.hold_any} !== 9'b0001_0010_1) begin
      n_err++; $display("FAIL cont_first: got %b want 000100101",
                        {bus.grant, bus.hold, bus.hold_any});
    end
    drive(4'b0010);
    n_cmp++;
    if ({bus.grant, bus.grant_id} !== 6'b0010_01) begin
      n_err++; $display("FAIL cont_handoff: got %b want 001001", {bus.grant, bus.grant_id});
    end
    drive(4'b0110);
    n_cmp++;
    if ({bus.grant, bus.hold} !== 8'b0010_0100) begin
      n_err++; $display("FAIL cont_nonowner_req: got %b want 00100100", {bus.grant, bus.hold});
    end
    drive(4'b0010);
    n_cmp++;
    if ({bus.grant, bus.hold, bus.hold_any} !== 9'b0010_0000_0) begin
      n_err++; $display("FAIL cont_nonowner_drop: got %b want 001000000",
                        {bus.grant, bus.hold, bus.hold_any});
    end
    drive(4'b0000);
  endtask

  task automatic test_fairness();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    drive(4'b1111);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'(seq[g])) begin
          n_err++; $display("FAIL fair_g%0d_c%0d: got valid=%b id=%0d want valid=1 id=%0d",
                            g, c, bus.grant_valid, bus.grant_id, seq[g]);
        end
        if (c == 0) drive(4'b1111);
      end
      drive(4'b1111 & ~(4'b0001 << seq[g]));
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(4'b0010);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0011);
      n_cmp++;
      if ({bus.grant, bus.hold} !== 8'b0010_0001) begin
        n_err++; $display("FAIL lock_c%0d: got %b want 00100001", c, {bus.grant, bus.hold});
      end
    end
    drive(4'b0001);
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_err++; $display("FAIL lock_release: got %b want 0001", bus.grant);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= MAXH; c++) begin
      drive(4'b0011);
      n_cmp++;
      if ({bus.grant, bus.timeout} !== 5'b0001_0) begin
        n_err++; $display("FAIL tmo_owned c%0d: got %b want 00010", c, {bus.grant, bus.timeout});
      end
    end
    drive(4'b0011);
    n_cmp++;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
    if ({bus.grant, bus.timeout, bus.hold} !== 9'b0010_1_0001) begin
      n_err++; $display("FAIL tmo_revoke: got %b want 001010001",
                        {bus.grant, bus.timeout, bus.hold});
    end
    drive(4'b0011);
    n_cmp++;
    if ({bus.grant, bus.timeout} !== 5'b0010_0) begin
      n_err++; $display("FAIL tmo_pulse_end: got %b want 00100", {bus.grant, bus.timeout});
    end
    drive(4'b0001);
    n_cmp++;
    if ({bus.grant_valid, bus.hold} !== 5'b0_0001) begin
      n_err++; $display("FAIL tmo_masked: got %b want 00001", {bus.grant_valid, bus.hold});
    end
    drive(4'b0000);
    drive(4'b0001);
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_err++; $display("FAIL tmo_rearm: got %b want 0001", bus.grant);
    end
`else
    if ({bus.grant, bus.timeout} !== 5'b0001_0) begin
      n_err++; $display("FAIL tmo_disabled: got %b want 00010", {bus.grant, bus.timeout});
    end
`endif
    drive(4'b0000);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    r = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
      drive(r);
      eg = m_grant();
      n_cmp++;
      if (bus.grant !== eg || bus.grant_valid !== (m_owner >= 0) ||
          bus.grant_id !== 2'((m_owner < 0) ? 0 : m_owner) || bus.timeout !== m_tmo ||
          bus.hold !== (r & ~eg) || bus.hold_any !== |(r & ~eg)) begin
        n_err++;
        $display("FAIL rand c%0d req=%b: got g=%b v=%b id=%0d t=%b h=%b ha=%b want g=%b owner=%0d t=%b h=%b",
                 c, r, bus.grant, bus.grant_valid, bus.grant_id, bus.timeout, bus.hold,
                 bus.hold_any, eg, m_owner, m_tmo, r & ~eg);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_lock();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
